// File: rtl/pwm_ramp_pkg.sv
// Shared types, default widths and the perceptual duty curve for the PWM ramp controller.
package pwm_ramp_pkg;

    localparam int unsigned DUTY_W_DEF = 8;
    localparam int unsigned DIV_W_DEF  = 16;
    localparam int unsigned STEP_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    // (v*(v+1)) >> width : maps 0->0 and full-scale->full-scale with a squared shape.
    function automatic logic [31:0] gamma_curve(input logic [31:0] v, input int unsigned width);
        logic [63:0] prod;
        prod = 64'(v) * (64'(v) + 64'd1);
        return 32'(prod >> width);
    endfunction

endpackage

// File: rtl/pwm_ramp_controller_if.sv
// Register-bank side bundle of the PWM ramp controller: ramp request in, duty/status out.
interface pwm_ramp_controller_if #(
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned STEP_W = 8
);
    logic [DUTY_W-1:0] target_duty;
    logic [DIV_W-1:0]  step_div;
    logic [STEP_W-1:0] step_size;
    logic              start;
    logic              abort;
    logic [DUTY_W-1:0] duty_out;
    logic              busy;
    logic              done;

    modport master (
        output target_duty, step_div, step_size, start, abort,
        input  duty_out, busy, done
    );

    modport slave (
        input  target_duty, step_div, step_size, start, abort,
        output duty_out, busy, done
    );
endinterface

// File: rtl/pwm_ramp_prescaler.sv
// Clock-edge divider for the duty ramp: emits a one-cycle tick every div enabled cycles.
module pwm_ramp_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q;
    logic             wrap;

    // div is always >= 1 here; the controller substitutes 1 for a zero request.
    assign wrap = (cnt_q == div - DIV_W'(1));
    assign tick = enable && wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= wrap ? '0 : cnt_q + DIV_W'(1);
        end
    end
endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramps the PWM duty toward a requested target at a programmable rate, with retarget/abort.
// Optional perceptual output curve: define PWM_RAMP_GAMMA_EN.
module pwm_ramp_controller
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned DUTY_W = DUTY_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_ramp_controller_if.slave bus
);
    localparam int unsigned SUM_W = ((DUTY_W > STEP_W) ? DUTY_W : STEP_W) + 1;

    ramp_state_t       state_q, state_d;
    logic [DUTY_W-1:0] lin_q, lin_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              done_q, done_d;
    logic              accept;
    logic              tick;
    logic [SUM_W-1:0]  up_sum;
    logic [SUM_W-1:0]  down_gap;

    pwm_ramp_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .enable(state_q != IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        lin_d    = lin_q;
        tgt_d    = tgt_q;
        div_d    = div_q;
        step_d   = step_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        up_sum   = SUM_W'(lin_q) + SUM_W'(step_q);
        down_gap = SUM_W'(lin_q - tgt_q);

        // abort beats start; a start beats a coincident step tick
        if (bus.abort) begin
            state_d = IDLE;
        end else if (bus.start) begin
            accept = 1'b1;
            tgt_d  = bus.target_duty;
            div_d  = (bus.step_div == '0) ? DIV_W'(1) : bus.step_div;
            step_d = (bus.step_size == '0) ? STEP_W'(1) : bus.step_size;
            if (bus.target_duty > lin_q) begin
                state_d = UP;
            end else if (bus.target_duty < lin_q) begin
                state_d = DOWN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (tick) begin
            case (state_q)
                UP: begin
                    if (up_sum >= SUM_W'(tgt_q)) begin
                        lin_d   = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        lin_d = lin_q + DUTY_W'(step_q);
                    end
                end
                DOWN: begin
                    if (down_gap <= SUM_W'(step_q)) begin
                        lin_d   = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        lin_d = lin_q - DUTY_W'(step_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lin_q   <= '0;
            tgt_q   <= '0;
            div_q   <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lin_q   <= lin_d;
            tgt_q   <= tgt_d;
            div_q   <= div_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

`ifdef PWM_RAMP_GAMMA_EN
    assign bus.duty_out = DUTY_W'(gamma_curve(32'(lin_q), DUTY_W));
`else
    assign bus.duty_out = lin_q;
`endif
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Randomised scoreboard bench for pwm_ramp_controller against a countdown-based reference model.
module tb_pwm_ramp_controller;

    typedef struct {
        int duty;
        bit busy;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    // reference model state: dir 0 idle, +1 rising, -1 falling; cnt = cycles until next step
    int m_lin = 0, m_tgt = 0, m_div = 0, m_step = 0, m_dir = 0, m_cnt = 0;
    bit m_done = 1'b0;

    pwm_ramp_controller_if #(.DUTY_W(8), .DIV_W(16), .STEP_W(8)) bus ();

    pwm_ramp_controller #(.DUTY_W(8), .DIV_W(16), .STEP_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int out_curve(input int v);
`ifdef PWM_RAMP_GAMMA_EN
        return (v * (v + 1)) >> 8;
`else
        return v;
`endif
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit a, input int tgt, input int dv, input int st);
        m_done = 1'b0;
        if (r) begin
            m_lin = 0; m_tgt = 0; m_div = 0; m_step = 0; m_dir = 0; m_cnt = 0;
        end else if (a) begin
            m_dir = 0;
        end else if (s) begin
            m_tgt  = tgt;
            m_div  = (dv == 0) ? 1 : dv;
            m_step = (st == 0) ? 1 : st;
            m_cnt  = m_div;
            if (tgt > m_lin) m_dir = 1;
            else if (tgt < m_lin) m_dir = -1;
            else begin
                m_dir  = 0;
                m_done = 1'b1;
            end
        end else if (m_dir != 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_cnt = m_div;
                if (m_dir > 0) m_lin = (m_lin + m_step > m_tgt) ? m_tgt : m_lin + m_step;
                else           m_lin = (m_lin - m_step < m_tgt) ? m_tgt : m_lin - m_step;
                if (m_lin == m_tgt) begin
                    m_dir  = 0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit a, input int tgt, input int dv, input int st);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.start       = s;
        bus.abort       = a;
        bus.target_duty = 8'(tgt);
        bus.step_div    = 16'(dv);
        bus.step_size   = 8'(st);
        model_edge(r, s, a, tgt, dv, st);
        e.duty = out_curve(m_lin);
        e.busy = (m_dir != 0);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    // parameter buses wiggle without start; the design must ignore them
    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, int'($urandom_range(255)), int'($urandom_range(7)), int'($urandom_range(255)));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int i;
        i = 0;
        while (m_dir != 0 && i < max_cycles) begin
            idle();
            i++;
        end
        checks++;
        if (m_dir != 0) begin
            errors++;
            $display("FAIL ramp_complete: still ramping after %0d cycles, required idle", max_cycles);
        end
    endtask

    task automatic run_until_lin(input int v, input int max_cycles);
        int i;
        i = 0;
        while (m_lin != v && i < max_cycles) begin
            idle();
            i++;
        end
        checks++;
        if (m_lin != v) begin
            errors++;
            $display("FAIL reach_level: level %0d after %0d cycles, required %0d", m_lin, max_cycles, v);
        end
    endtask

    // monitor: every output edge is compared against the oldest queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [7:0] ed;
                e  = exp_q.pop_front();
                ed = 8'(e.duty);
                checks++;
                if (bus.duty_out !== ed || bus.busy !== e.busy || bus.done !== e.done) begin
                    errors++;
                    $display("FAIL outputs @%0t: duty=%0d busy=%b done=%b, required duty=%0d busy=%b done=%b",
                             $time, bus.duty_out, bus.busy, bus.done, ed, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.target_duty = '0;
        bus.step_div    = '0;
        bus.step_size   = '0;

        // reset, with a start pulse that must be ignored
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cycle(1'b1, 1'b1, 1'b0, 99, 1, 1);
        idle_n(2);

        // up-ramp 0 -> 10, div 4, step 3
        cycle(1'b0, 1'b1, 1'b0, 10, 4, 3);
        idle_n(20);

        // down-ramp 10 -> 0, div 1, step 4
        cycle(1'b0, 1'b1, 1'b0, 0, 1, 4);
        idle_n(6);

        // retarget mid-ramp: 0 -> 200 abandoned at 50, new target 20
        cycle(1'b0, 1'b1, 1'b0, 200, 1, 1);
        run_until_lin(50, 300);
        cycle(1'b0, 1'b1, 1'b0, 20, 1, 1);
        run_until_idle(100);
        idle_n(3);

        // abort at 37, then start+abort, then equal-target start
        cycle(1'b0, 1'b1, 1'b0, 100, 1, 1);
        run_until_lin(37, 100);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle_n(3);
        cycle(1'b0, 1'b1, 1'b1, 200, 1, 1);
        idle_n(3);
        cycle(1'b0, 1'b1, 1'b0, 37, 2, 2);
        idle_n(2);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle_n(2);

        // zero div/step behave as 1
        cycle(1'b0, 1'b1, 1'b0, 40, 0, 0);
        run_until_idle(20);
        idle_n(2);

        // clamp at full scale and at zero
        cycle(1'b0, 1'b1, 1'b0, 255, 2, 200);
        run_until_idle(20);
        cycle(1'b0, 1'b1, 1'b0, 0, 3, 255);
        run_until_idle(20);
        idle_n(2);

        // curve points at 128 and 255
        cycle(1'b0, 1'b1, 1'b0, 128, 1, 64);
        run_until_idle(20);
        idle();
        cycle(1'b0, 1'b1, 1'b0, 255, 1, 100);
        run_until_idle(20);
        idle();

        // reset in the middle of a ramp
        cycle(1'b0, 1'b1, 1'b0, 100, 3, 5);
        idle_n(10);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle_n(3);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, s, a;
            r = ($urandom_range(299) == 0);
            s = ($urandom_range(9) == 0);
            a = ($urandom_range(39) == 0);
            cycle(r, s, a, int'($urandom_range(255)), int'($urandom_range(5)), int'($urandom_range(60)));
        end
        idle_n(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unconsumed, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Duty-cycle sequencer between the SPI register bank and the PWM peripheral. Rather than letting a new duty value jump the PWM output instantly, it ramps the duty value presented to the PWM peripheral from its current level toward a requested target. Ramp rate is set by a step size and a clock-tick divider. The block reports progress with busy/done status and supports mid-ramp retargeting and abort.

## Interface
Parameters:
- DUTY_W, 8, duty value width
- DIV_W, 16, step-divider width
- STEP_W, 8, step-size width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- target_duty  in  DUTY_W  requested final duty (from SPI register)
- step_div  in  DIV_W  clock edges between duty steps; 0 treated as 1
- step_size  in  STEP_W  duty increment per step; 0 treated as 1
- start  in  1  single-cycle request: latch target_duty/step_div/step_size, begin ramp
- abort  in  1  stop ramp, hold current duty
- duty_out  out  DUTY_W  duty value to PWM peripheral
- busy  out  1  high while ramping
- done  out  1  one-cycle pulse when duty reaches target

## Operation
- Internal linear duty register `lin`; states IDLE, UP, DOWN; `busy` = (state != IDLE).
- Reset: state IDLE, lin=0, duty_out=0, busy=0, done=0, prescaler=0, latched params=0.
- start accepted in any state, unless abort is high the same cycle (abort wins, start dropped). On accept:
  - latch target, effective div, effective step
  - clear prescaler
  - next state: UP if target > lin; DOWN if target < lin; IDLE with done=1 if equal
- Mid-ramp start retargets: direction recomputed from current lin; no done for the abandoned target.
- UP/DOWN: prescaler increments each cycle. On the cycle prescaler == div-1, prescaler wraps to 0 and lin steps:
  - UP: 9-bit sum; lin = min(lin+step, target)
  - DOWN: lin = target if (lin-target) <= step, else lin-step
  - never overshoots, never wraps past 0/255
- Step landing on target: same edge writes lin=target, state→IDLE, done=1 for one cycle.
- abort in UP/DOWN: state→IDLE, lin frozen, done stays 0. abort in IDLE: no effect.
- target_duty/step_div/step_size changes without start are ignored.

## Timing
- All outputs registered; no combinational input→output path.
- Edge E0 samples start; first lin change occurs at edge E0+div; subsequent changes every div edges.
- div=1: lin changes every cycle after start.
- done and the busy falling edge coincide with the final lin update.
- Equal-target start: done high for the cycle after E0; busy never rises.
- Sync reset mid-ramp: at the next edge, all outputs return to reset values; no done.

## Configuration
- PWM_RAMP_GAMMA_EN defined: duty_out = (lin*(lin+1))>>8, a perceptual curve mapping 0→0, 128→64, 255→255. The output is computed from the registered lin, adding no cycles of latency.
- Undefined: duty_out = lin.
- Ramp and status behaviour are identical in both builds.

## Structure
- Package pwm_ramp_pkg holds:
  - state enum (IDLE, UP, DOWN)
  - DUTY_W/DIV_W/STEP_W defaults
  - gamma function
- Sub-module pwm_ramp_prescaler:
  - inputs: clear, enable, div
  - output: one-cycle step tick
  - the FSM and arithmetic stay in the top module.

## Test plan
- Reset: hold rst 2 cycles → duty_out=0, busy=0, done=0; start pulses during rst ignored.
- Up-ramp: lin=0, start target=10, div=4, step=3 → duty_out 3,6,9,10 at E0+4,+8,+12,+16; done and busy fall together at E0+16.
- Down-ramp: lin=10, start target=0, div=1, step=4 → 6,2,0 on consecutive cycles; done with the 0 update.
- Retarget: ramp 0→200 (div=1, step=1); at lin=50 start target=20 → lin decreases to 20; exactly one done, at 20.
- Abort: mid-ramp at lin=37 assert abort → lin holds 37, busy=0 next cycle, no done. start+abort same cycle → ignored. start with target==lin → done pulse, busy stays 0.
- Gamma (PWM_RAMP_GAMMA_EN): ramp to 128 → duty_out=64; ramp to 255 → 255.
